rob_alloc: RTL and testbench
============================

Name: rob_alloc

Overview:
- Reorder-buffer responder for the decode stage's tag-request protocol.
- Hands out the next free ROB tag and a full flag, and accepts allocations (rd, op).
- Captures execution-unit writebacks by tag and retires entries in program order to the register-file writeback path.
- Sits between decode (initiator), the writeback bus (wb) and the register file.

Parameters:
ENTRIES, 8, number of ROB entries; valid tags are 1..ENTRIES, tag 0 = TAG_INVALID
TAG_W, 4, tag width; must satisfy 2^TAG_W > ENTRIES
REG_W, 5, architectural register index width
OP_W, 6, op-type width (matches decode op field)
DATA_W, 32, result width

Ports:
clk  input  1  clock, all state changes on posedge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous squash of all entries (rst_tag)
tag_token  input  1  decode requests allocation this cycle
alloc_rd  input  REG_W  destination register of allocated inst
alloc_op  input  OP_W  op type of allocated inst
avail_tag  output  TAG_W  tag the next allocation receives; 0 when full
full  output  1  no free entry
empty  output  1  no busy entry
wb_valid  input  1  writeback strobe
wb_tag  input  TAG_W  tag being written back
wb_val  input  DATA_W  result value
commit_valid  output  1  one-cycle retire pulse
commit_tag  output  TAG_W  retired tag
commit_rd  output  REG_W  retired destination register
commit_val  output  DATA_W  retired value
qry_tag1, qry_tag2  input  TAG_W  operand lookup tags (see Optional Feature)
qry_ready1, qry_ready2  output  1  lookup entry has result
qry_val1, qry_val2  output  DATA_W  lookup result

Behaviour:
- State:
  - head and tail indices, 0..ENTRIES-1, wrapping ENTRIES-1 -> 0.
  - count, 0..ENTRIES.
  - Per entry: busy, ready, rd, op, val.
  - Tag = index+1.
- Reset (async) and flush (sync):
  - busy/ready all 0; head = tail = count = 0.
  - commit_valid = 0; commit_tag/rd/val = 0.
  - Flush has priority over alloc, wb and commit in the same cycle.
- Combinational outputs:
  - full = (count == ENTRIES).
  - empty = (count == 0).
  - avail_tag = full ? 0 : tail+1.
  - Decode may change tag_token/alloc_* on negedge; this block samples on posedge only.
- Allocate (tag_token && !full):
  - entry[tail] busy=1, ready=0, rd, op stored.
  - tail advances.
  - tag_token while full is ignored; no state change.
- Writeback (wb_valid && wb_tag != 0 && entry[wb_tag-1].busy):
  - val stored, ready = 1.
  - wb_tag == 0, wb_tag > ENTRIES, or a non-busy target: ignored.
  - A repeat writeback to an already-ready entry overwrites val.
- Commit:
  - If entry[head] busy && ready at the posedge: commit_valid=1 next cycle with that entry's tag/rd/val; entry busy=0; head advances.
  - At most one retire per cycle.
  - Otherwise commit_valid=0; commit_tag/rd/val hold their last values.
  - rd == 0 still commits; the register file discards it.
- Ready state is sampled pre-edge:
  - A writeback and a commit check on the same entry in the same cycle do not bypass; that entry retires one cycle later.
  - Minimum latency: alloc edge N, wb edge N+1, commit_valid high after edge N+2.
- Simultaneous events:
  - Alloc + commit in one cycle: count unchanged.
  - When full, alloc is rejected even if a commit frees an entry that same edge (no bypass).
  - An alloc to the entry freed by the same-cycle commit is impossible, because full blocks it.
  - Alloc and wb to the same index in one cycle: the wb is ignored, since the entry is not yet busy.

Optional Feature:
- Macro: ROB_FWD_EN.
- Defined:
  - qry_readyN = busy && ready for entry qry_tagN-1; qry_valN = its val.
  - Same-cycle bypass: if wb qualifies and wb_tag == qry_tagN, qry_readyN=1 and qry_valN=wb_val.
  - qry_tagN == 0 gives ready=0, val=0.
- Not defined: qry_ready1/2 and qry_val1/2 tied to 0; qry_tag inputs unused.

Test Plan:
- Reset then 8 allocs (rd=1..8):
  - avail_tag sequence 1..8.
  - full=1 after the 8th; avail_tag=0.
  - A 9th tag_token causes no change.
- Alloc rd=5, wb tag1 val=0xDEADBEEF: commit_valid pulses one cycle with tag=1, rd=5, val=0xDEADBEEF; empty=1 afterwards.
- Out-of-order completion: alloc tags 1,2,3; wb tag3 then tag2 then tag1. Commits follow as tag1, tag2, tag3 on consecutive cycles, each after tag1's wb.
- Wrap: fill, retire 3, allocate 3 more. avail_tag goes 1,2,3 again; order and values are preserved across the wrap.
- Flush asserted the same cycle as tag_token and wb: no commit; empty=1 and avail_tag=1 next cycle. Then assert rst mid-stream: outputs clear immediately, without waiting for a clk edge.
- With ROB_FWD_EN: qry_tag1=2 with wb_tag=2, wb_val=0x55 gives qry_ready1=1, qry_val1=0x55 the same cycle. Without the macro, both stay 0.

Source files
------------

// File: rtl/rob_alloc.sv
// Reorder buffer: hands out tags to decode, captures writebacks by tag, retires in order.
// Optional operand lookup with same-cycle writeback bypass when ROB_FWD_EN is defined.
module rob_alloc #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              tag_token,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic [OP_W-1:0]   alloc_op,
  output logic [TAG_W-1:0]  avail_tag,
  output logic              full,
  output logic              empty,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_val,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_val,
  input  logic [TAG_W-1:0]  qry_tag1,
  input  logic [TAG_W-1:0]  qry_tag2,
  output logic              qry_ready1,
  output logic              qry_ready2,
  output logic [DATA_W-1:0] qry_val1,
  output logic [DATA_W-1:0] qry_val2
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ENTRIES-1:0]             busy_q, busy_d;
  logic [ENTRIES-1:0]             ready_q, ready_d;
  logic [ENTRIES-1:0][REG_W-1:0]  rd_q, rd_d;
  logic [ENTRIES-1:0][OP_W-1:0]   op_q, op_d;
  logic [ENTRIES-1:0][DATA_W-1:0] val_q, val_d;

  logic              commit_valid_q, commit_valid_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
  logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0] commit_val_q, commit_val_d;

  logic             do_alloc, do_commit, wb_hit;
  logic [IDX_W-1:0] wb_idx;

  assign full      = (count_q == CNT_W'(ENTRIES));
  assign empty     = (count_q == '0);
  assign avail_tag = full ? '0 : TAG_W'(tail_q) + TAG_W'(1);

  // A writeback only lands on an in-range, currently busy entry.
  assign wb_idx    = IDX_W'(wb_tag - TAG_W'(1));
  assign wb_hit    = wb_valid && (wb_tag != '0) && (32'(wb_tag) <= ENTRIES) && busy_q[wb_idx];
  assign do_alloc  = tag_token && !full;
  assign do_commit = busy_q[head_q] && ready_q[head_q];

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(ENTRIES - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Next-state: writeback, then retire, then allocate; flush overrides everything.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    rd_d           = rd_q;
    op_d           = op_q;
    val_d          = val_q;
    commit_valid_d = 1'b0;
    commit_tag_d   = commit_tag_q;
    commit_rd_d    = commit_rd_q;
    commit_val_d   = commit_val_q;

    if (flush) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      busy_d       = '0;
      ready_d      = '0;
      commit_tag_d = '0;
      commit_rd_d  = '0;
      commit_val_d = '0;
    end else begin
      if (wb_hit) begin
        val_d[wb_idx]   = wb_val;
        ready_d[wb_idx] = 1'b1;
      end
      // Retire uses pre-edge ready/val, so a same-cycle writeback never bypasses.
      if (do_commit) begin
        commit_valid_d  = 1'b1;
        commit_tag_d    = TAG_W'(head_q) + TAG_W'(1);
        commit_rd_d     = rd_q[head_q];
        commit_val_d    = val_q[head_q];
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = wrap_inc(head_q);
      end
      if (do_alloc) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = alloc_rd;
        op_d[tail_q]    = alloc_op;
        tail_d          = wrap_inc(tail_q);
      end
      count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      rd_q           <= '0;
      op_q           <= '0;
      val_q          <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      rd_q           <= rd_d;
      op_q           <= op_d;
      val_q          <= val_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_rd_q    <= commit_rd_d;
      commit_val_q   <= commit_val_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign commit_rd    = commit_rd_q;
  assign commit_val   = commit_val_q;

`ifdef ROB_FWD_EN
  // Returns {ready, val}; a qualifying writeback to the same tag wins over stored state.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
    logic [IDX_W-1:0] idx;
    logic [DATA_W:0]  res;
    res = '0;
    idx = IDX_W'(tag - TAG_W'(1));
    if ((tag != '0) && (32'(tag) <= ENTRIES)) begin
      if (wb_hit && (wb_tag == tag)) res = {1'b1, wb_val};
      else if (busy_q[idx] && ready_q[idx]) res = {1'b1, val_q[idx]};
    end
    return res;
  endfunction

  always_comb {qry_ready1, qry_val1} = lookup(qry_tag1);
  always_comb {qry_ready2, qry_val2} = lookup(qry_tag2);

  logic unused_c;
  assign unused_c = ^op_q;
`else
  assign qry_ready1 = 1'b0;
  assign qry_ready2 = 1'b0;
  assign qry_val1   = '0;
  assign qry_val2   = '0;

  logic unused_c;
  assign unused_c = ^{op_q, qry_tag1, qry_tag2};
`endif

endmodule

// File: tb/tb_rob_alloc.sv
// Directed bench for rob_alloc: allocation, in-order retire, wrap, flush, async reset, lookup.
module tb_rob_alloc;

  logic        clk, rst, flush, tag_token;
  logic [4:0]  alloc_rd;
  logic [5:0]  alloc_op;
  logic [3:0]  avail_tag;
  logic        full, empty;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_val;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  qry_tag1, qry_tag2;
  logic        qry_ready1, qry_ready2;
  logic [31:0] qry_val1, qry_val2;

  int n_chk  = 0;
  int n_pass = 0;

  rob_alloc dut (
    .clk(clk), .rst(rst), .flush(flush), .tag_token(tag_token),
    .alloc_rd(alloc_rd), .alloc_op(alloc_op), .avail_tag(avail_tag),
    .full(full), .empty(empty), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_val(wb_val), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_val(commit_val), .qry_tag1(qry_tag1),
    .qry_tag2(qry_tag2), .qry_ready1(qry_ready1), .qry_ready2(qry_ready2),
    .qry_val1(qry_val1), .qry_val2(qry_val2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_commit(input string tag, input int t, input int rd, input logic [31:0] v);
    chk({tag, "_cv"},  32'(commit_valid), 32'd1);
    chk({tag, "_tag"}, 32'(commit_tag), 32'(t));
    chk({tag, "_rd"},  32'(commit_rd), 32'(rd));
    chk({tag, "_val"}, commit_val, v);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  int exp_tag [8] = '{4, 5, 6, 7, 8, 1, 2, 3};
  int exp_rd  [8] = '{4, 5, 6, 7, 8, 20, 21, 22};

  initial begin
    logic [31:0] ev;
    rst = 1'b1; flush = 1'b0; tag_token = 1'b0; alloc_rd = '0; alloc_op = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_val = '0; qry_tag1 = '0; qry_tag2 = '0;
    #12;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_avail", 32'(avail_tag), 32'd1);
    chk("rst_cv", 32'(commit_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Fill all eight entries, then a rejected ninth request.
    for (int i = 0; i < 8; i++) begin
      chk("fill_avail", 32'(avail_tag), 32'(i + 1));
      chk("fill_full", 32'(full), 32'd0);
      tag_token = 1'b1; alloc_rd = 5'(i + 1); alloc_op = 6'(i);
      tick();
    end
    tag_token = 1'b0;
    chk("full_set", 32'(full), 32'd1);
    chk("full_avail0", 32'(avail_tag), 32'd0);
    chk("full_nempty", 32'(empty), 32'd0);
    tag_token = 1'b1; alloc_rd = 5'd31;
    tick();
    tag_token = 1'b0;
    chk("ninth_full", 32'(full), 32'd1);
    chk("ninth_avail", 32'(avail_tag), 32'd0);
    chk("ninth_cv", 32'(commit_valid), 32'd0);
    do_flush();
    chk("fl1_empty", 32'(empty), 32'd1);
    chk("fl1_avail", 32'(avail_tag), 32'd1);

    // Minimum-latency single entry.
    tag_token = 1'b1; alloc_rd = 5'd5;
    tick();
    tag_token = 1'b0; wb_valid = 1'b1; wb_tag = 4'd1; wb_val = 32'hDEADBEEF;
    tick();
    wb_valid = 1'b0;
    chk("lat_cv_early", 32'(commit_valid), 32'd0);
    tick();
    chk_commit("lat", 1, 5, 32'hDEADBEEF);
    chk("lat_empty", 32'(empty), 32'd1);
    tick();
    chk("lat_cv_drop", 32'(commit_valid), 32'd0);
    chk("lat_tag_hold", 32'(commit_tag), 32'd1);

    // Out-of-order completion retires in order.
    do_flush();
    for (int i = 0; i < 3; i++) begin
      tag_token = 1'b1; alloc_rd = 5'(10 + i);
      tick();
    end
    tag_token = 1'b0;
    for (int t = 3; t >= 1; t--) begin
      wb_valid = 1'b1; wb_tag = 4'(t); wb_val = 32'(t * 'h11);
      tick();
      chk("ooo_no_cv", 32'(commit_valid), 32'd0);
    end
    wb_valid = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk_commit("ooo", t, 9 + t, 32'(t * 'h11));
    end
    chk("ooo_empty", 32'(empty), 32'd1);
    tick();
    chk("ooo_cv_drop", 32'(commit_valid), 32'd0);

    // Wrap: fill, retire tags 1..3, reallocate them, then drain everything.
    do_flush();
    for (int i = 0; i < 8; i++) begin
      tag_token = 1'b1; alloc_rd = 5'(i + 1);
      tick();
    end
    tag_token = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      wb_valid = (t <= 3); wb_tag = 4'(t); wb_val = 32'h100 + 32'(t);
      tick();
      if (t >= 2) chk_commit("wrap_ret", t - 1, t - 1, 32'h100 + 32'(t - 1));
      else chk("wrap_ret_cv0", 32'(commit_valid), 32'd0);
    end
    wb_valid = 1'b0;
    chk("wrap_full0", 32'(full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_avail", 32'(avail_tag), 32'(i + 1));
      tag_token = 1'b1; alloc_rd = 5'(20 + i);
      tick();
    end
    tag_token = 1'b0;
    chk("wrap_full1", 32'(full), 32'd1);
    for (int t = 1; t <= 3; t++) begin
      wb_valid = 1'b1; wb_tag = 4'(t); wb_val = 32'h200 + 32'(t);
      tick();
      chk("wrap_new_no_cv", 32'(commit_valid), 32'd0);
    end
    wb_tag = 4'd4; wb_val = 32'h104;
    tick();
    chk("wrap_h4_no_cv", 32'(commit_valid), 32'd0);
    for (int j = 0; j < 8; j++) begin
      wb_valid = (j < 4); wb_tag = 4'(5 + j); wb_val = 32'h100 + 32'(5 + j);
      tick();
      ev = (exp_tag[j] >= 4) ? 32'h100 + 32'(exp_tag[j]) : 32'h200 + 32'(exp_tag[j]);
      chk_commit("wrap_drain", exp_tag[j], exp_rd[j], ev);
    end
    wb_valid = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);

    // Flush beats a same-cycle commit, alloc and writeback.
    do_flush();
    tag_token = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_rd = 5'd8;
    tick();
    tag_token = 1'b0; wb_valid = 1'b1; wb_tag = 4'd1; wb_val = 32'h44;
    tick();
    flush = 1'b1; tag_token = 1'b1; alloc_rd = 5'd9; wb_tag = 4'd2; wb_val = 32'h45;
    tick();
    flush = 1'b0; tag_token = 1'b0; wb_valid = 1'b0;
    chk("flush_cv", 32'(commit_valid), 32'd0);
    chk("flush_tag0", 32'(commit_tag), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_avail", 32'(avail_tag), 32'd1);

    // Out-of-range and zero-tag writebacks must not mark tag 1 ready.
    tag_token = 1'b1; alloc_rd = 5'd3;
    tick();
    tag_token = 1'b0; wb_valid = 1'b1; wb_tag = 4'd9; wb_val = 32'h1;
    tick();
    wb_tag = 4'd0;
    tick();
    wb_valid = 1'b0;
    tick();
    chk("badwb_cv", 32'(commit_valid), 32'd0);
    chk("badwb_nempty", 32'(empty), 32'd0);

    // Async reset clears outputs with no clock edge.
    wb_valid = 1'b1; wb_tag = 4'd1; wb_val = 32'h99; tag_token = 1'b1; alloc_rd = 5'd4;
    tick();
    wb_valid = 1'b0; tag_token = 1'b0;
    tick();
    chk_commit("pre_rst", 1, 3, 32'h99);
    chk("pre_rst_avail", 32'(avail_tag), 32'd3);
    rst = 1'b1;
    #2;
    chk("arst_cv", 32'(commit_valid), 32'd0);
    chk("arst_tag", 32'(commit_tag), 32'd0);
    chk("arst_val", commit_val, 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_avail", 32'(avail_tag), 32'd1);
    #2;
    rst = 1'b0;
    tick();

    // Operand lookup with same-cycle bypass.
    tag_token = 1'b1; alloc_rd = 5'd1;
    tick();
    alloc_rd = 5'd2;
    tick();
    tag_token = 1'b0;
    wb_valid = 1'b1; wb_tag = 4'd2; wb_val = 32'h55; qry_tag1 = 4'd2; qry_tag2 = 4'd0;
    #1;
`ifdef ROB_FWD_EN
    chk("qry_byp_rdy", 32'(qry_ready1), 32'd1);
    chk("qry_byp_val", qry_val1, 32'h55);
`else
    chk("qry_off_rdy", 32'(qry_ready1), 32'd0);
    chk("qry_off_val", qry_val1, 32'd0);
`endif
    chk("qry_t0_rdy", 32'(qry_ready2), 32'd0);
    chk("qry_t0_val", qry_val2, 32'd0);
    tick();
    wb_valid = 1'b0; qry_tag2 = 4'd1;
    #1;
`ifdef ROB_FWD_EN
    chk("qry_st_rdy", 32'(qry_ready1), 32'd1);
    chk("qry_st_val", qry_val1, 32'h55);
`else
    chk("qry_st_off", 32'(qry_ready1), 32'd0);
`endif
    chk("qry_nrdy", 32'(qry_ready2), 32'd0);
    chk("qry_cv", 32'(commit_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
